// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Holds the FSM state encoding, the pass-mode constants and the counter width helper.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StVerify = 2'd2,
        StDone   = 2'd3
    } ccff_ld_state_t;

    localparam logic CCFF_MODE_LOAD   = 1'b0;
    localparam logic CCFF_MODE_VERIFY = 1'b1;

    // Wide enough to hold CHAIN_LEN itself, since the counter stops there.
    function automatic int unsigned ccff_cnt_w(input int unsigned chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that feeds the chain one bit per shift cycle, LSB first.
// Generates a registered s_ready that lets back-to-back words stream without bubbles.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = ccff_cnt_w(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              active_next,
    input  logic              advance,
    input  logic [CNT_W-1:0]  cnt_next,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bit_valid,
    output logic              cur_bit
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1   = CNT_W'(CHAIN_LEN - 1);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              take;

    assign take = s_valid && ready_q;

    always_comb begin
        buf_d   = buf_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (!active_next) begin
            // Leaving the pass discards whatever is left of the final word.
            valid_d = 1'b0;
            idx_d   = '0;
        end else if (take) begin
            buf_d   = s_data;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (advance && valid_q) begin
            if (idx_q == LAST_IDX) begin
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Ready next cycle if the buffer will be empty or on its last bit, and the chain
    // still needs bits beyond what the buffer will have delivered by then.
    always_comb begin
        ready_d = 1'b0;
        if (active_next && (!valid_d || idx_d == LAST_IDX)) begin
            ready_d = valid_d ? (cnt_next < LEN_M1) : (cnt_next < LEN);
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            buf_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign s_ready   = ready_q;
    assign bit_valid = valid_q;
    assign cur_bit   = buf_q[idx_q];

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads or verifies a tile configuration chain from a word-wide bitstream source.
// Verify rotates the chain through itself, so a full pass leaves the contents unchanged.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              cmd_start,
    input  logic              cmd_verify,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_shift_en,
    output logic              busy,
    output logic              done,
    output logic              verify_err
);

    localparam int unsigned CNT_W = ccff_cnt_w(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    ccff_ld_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             shift;
    logic             active_next;
    logic             bit_valid;
    logic             cur_bit;

    assign busy  = (state_q == StLoad) || (state_q == StVerify);
    assign shift = busy && bit_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    state_d = (cmd_verify == CCFF_MODE_VERIFY) ? StVerify : StLoad;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad, StVerify: begin
                if (shift) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == StVerify && ccff_tail != cur_bit) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign active_next = (state_d == StLoad) || (state_d == StVerify);

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    ccff_word_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) u_serializer (
        .prog_clk    (prog_clk),
        .prog_reset  (prog_reset),
        .active_next (active_next),
        .advance     (shift),
        .cnt_next    (cnt_d),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .bit_valid   (bit_valid),
        .cur_bit     (cur_bit)
    );

    // Verify feeds the tail straight back so the chain rotates rather than being overwritten.
    assign ccff_head      = shift ? ((state_q == StVerify) ? ccff_tail : cur_bit) : 1'b0;
    assign chain_shift_en = shift;
    assign done           = (state_q == StDone);
    assign verify_err     = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 20-FF chain model hangs off head/tail, and expected chain
// contents come from the bitstream order (first bit ends nearest the tail).
module tb_ccff_chain_loader;

    localparam int CL = 20;
    localparam int WW = 8;

    logic          prog_clk = 1'b0;
    logic          prog_reset;
    logic          cmd_start;
    logic          cmd_verify;
    logic [WW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          chain_shift_en;
    logic          busy;
    logic          done;
    logic          verify_err;

    logic [CL-1:0] chain = '0;

    int errors = 0;
    int checks = 0;

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (chain_shift_en) chain <= {chain[CL-2:0], ccff_head};
    end
    assign ccff_tail = chain[CL-1];

    ccff_chain_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (WW)
    ) dut (
        .prog_clk       (prog_clk),
        .prog_reset     (prog_reset),
        .cmd_start      (cmd_start),
        .cmd_verify     (cmd_verify),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .chain_shift_en (chain_shift_en),
        .busy           (busy),
        .done           (done),
        .verify_err     (verify_err)
    );

    // Stream bit i lands in FF(CL-1-i); bits past CL are dropped.
    function automatic logic [CL-1:0] exp_chain(input logic [7:0] w0, w1, w2);
        logic [23:0] s;
        logic [CL-1:0] r;
        s = {w2, w1, w0};
        for (int i = 0; i < CL; i++) r[CL-1-i] = s[i];
        return r;
    endfunction

    // Runs one pass; cycle c is the c-th cycle after the edge that samples cmd_start.
    task automatic run_pass(input bit vfy, input logic [7:0] w0, w1, w2,
                            input int stall_len, input int ghost_at, input bit rand_stall,
                            output int n_shift, output int n_idle, output int done_at,
                            output int err_shift, output bit err_at_done,
                            output bit ready_late, output bit head_bad,
                            output bit c1_ok, output int first_c);
        logic [7:0] w [3];
        int wi, stall_rem, c;
        w[0] = w0; w[1] = w1; w[2] = w2;
        wi = 0; stall_rem = stall_len; c = 0;
        n_shift = 0; n_idle = 0; done_at = -1; err_shift = -1;
        err_at_done = 1'b0; ready_late = 1'b0; head_bad = 1'b0; c1_ok = 1'b0; first_c = -1;
        @(negedge prog_clk);
        cmd_start = 1'b1; cmd_verify = vfy; s_valid = 1'b0;
        while (c < 300 && done_at < 0) begin
            @(negedge prog_clk);
            c++;
            cmd_start  = (c == ghost_at);
            cmd_verify = ~vfy;
            if (c == 1) c1_ok = busy && s_ready && !verify_err && !chain_shift_en;
            if (verify_err && err_shift < 0) err_shift = n_shift;
            if (chain_shift_en) begin
                n_shift++;
                if (first_c < 0) first_c = c;
            end else begin
                if (busy) n_idle++;
                if (ccff_head !== 1'b0) head_bad = 1'b1;
            end
            if (done) begin
                done_at = c;
                err_at_done = verify_err;
            end
            if (wi == 3 && s_ready) ready_late = 1'b1;
            s_data = WW'($urandom);
            s_valid = 1'b0;
            if (wi < 3 && s_ready) begin
                if (wi == 2 && stall_rem > 0) stall_rem--;
                else if (rand_stall && $urandom_range(0, 2) == 0) s_valid = 1'b0;
                else begin
                    s_valid = 1'b1;
                    s_data = w[wi];
                    wi++;
                end
            end
        end
        cmd_start = 1'b0;
        s_valid = 1'b0;
        @(negedge prog_clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: busy=%0b done=%0b, required 0/0", busy, done);
        end
    endtask

    int ns, ni, da, es, fc;
    bit ead, rl, hb, c1;

    task automatic test_reset();
        prog_reset = 1'b1; cmd_start = 1'b0; cmd_verify = 1'b0; s_valid = 1'b0; s_data = '0;
        #12;
        checks++;
        if ({s_ready, ccff_head, chain_shift_en, busy, done, verify_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {s_ready, ccff_head, chain_shift_en, busy, done, verify_err});
        end
        @(negedge prog_clk);
        prog_reset = 1'b0;
        @(negedge prog_clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b s_ready=%0b, required 0/0", busy, s_ready);
        end
    endtask

    task automatic test_load();
        logic [CL-1:0] e;
        e = exp_chain(8'hA5, 8'h3C, 8'h0F);
        run_pass(1'b0, 8'hA5, 8'h3C, 8'h0F, 0, -1, 1'b0, ns, ni, da, es, ead, rl, hb, c1, fc);
        checks += 7;
        if (ns != CL) begin errors++; $display("FAIL load_shifts: got %0d, required %0d", ns, CL); end
        if (ni != 1) begin errors++; $display("FAIL load_gaps: idle busy cycles %0d, required 1", ni); end
        if (da != CL + 2) begin errors++; $display("FAIL load_done_cycle: got %0d, required %0d", da, CL + 2); end
        if (chain !== e) begin errors++; $display("FAIL load_chain: got %h, required %h", chain, e); end
        if (!c1 || fc != 2) begin errors++; $display("FAIL load_start_timing: c1_ok=%0b first_shift=%0d, required 1/2", c1, fc); end
        if (rl) begin errors++; $display("FAIL load_ready_after_last: s_ready high after last word"); end
        if (hb) begin errors++; $display("FAIL load_head_idle: ccff_head nonzero outside shift"); end
    endtask

    task automatic test_stall_load();
        logic [CL-1:0] e;
        e = exp_chain(8'hA5, 8'h3C, 8'h0F);
        chain = ~e;
        run_pass(1'b0, 8'hA5, 8'h3C, 8'h0F, 3, 5, 1'b0, ns, ni, da, es, ead, rl, hb, c1, fc);
        checks += 5;
        if (ns != CL) begin errors++; $display("FAIL stall_shifts: got %0d, required %0d", ns, CL); end
        if (ni - 1 != 3) begin errors++; $display("FAIL stall_gaps: got %0d, required 3", ni - 1); end
        if (da != CL + 5) begin errors++; $display("FAIL stall_done_cycle: got %0d, required %0d", da, CL + 5); end
        if (chain !== e) begin errors++; $display("FAIL stall_chain: got %h, required %h", chain, e); end
        if (hb) begin errors++; $display("FAIL stall_head: ccff_head nonzero during stall"); end
    endtask

    task automatic test_verify();
        logic [CL-1:0] e;
        e = exp_chain(8'hA5, 8'h3C, 8'h0F);
        run_pass(1'b1, 8'hA5, 8'h3C, 8'h0F, 0, -1, 1'b0, ns, ni, da, es, ead, rl, hb, c1, fc);
        checks += 3;
        if (es != -1 || ead) begin errors++; $display("FAIL verify_ok_err: err at shift %0d, required none", es); end
        if (chain !== e) begin errors++; $display("FAIL verify_ok_chain: got %h, required %h", chain, e); end
        if (da != CL + 2) begin errors++; $display("FAIL verify_ok_done: got %0d, required %0d", da, CL + 2); end
        run_pass(1'b1, 8'hA5, 8'h3D, 8'h0F, 0, -1, 1'b0, ns, ni, da, es, ead, rl, hb, c1, fc);
        checks += 4;
        if (es != 9) begin errors++; $display("FAIL verify_bad_rise: after shift %0d, required 9", es); end
        if (!ead) begin errors++; $display("FAIL verify_bad_at_done: verify_err=0, required 1"); end
        if (chain !== e) begin errors++; $display("FAIL verify_bad_chain: got %h, required %h", chain, e); end
        if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_err_sticky: got %0b, required 1", verify_err); end
        run_pass(1'b1, 8'hA5, 8'h3C, 8'h0F, 0, -1, 1'b0, ns, ni, da, es, ead, rl, hb, c1, fc);
        checks++;
        if (!c1 || es != -1) begin errors++; $display("FAIL verify_err_clear: c1_ok=%0b err_shift=%0d, required 1/-1", c1, es); end
    endtask

    task automatic test_random();
        logic [7:0] w0, w1, w2, f0, f1, f2;
        logic [23:0] flip;
        logic [CL-1:0] e;
        int p, exp_es;
        for (int it = 0; it < 6; it++) begin
            w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
            e = exp_chain(w0, w1, w2);
            run_pass(1'b0, w0, w1, w2, 0, -1, 1'b1, ns, ni, da, es, ead, rl, hb, c1, fc);
            checks += 3;
            if (chain !== e) begin errors++; $display("FAIL rand_load_chain[%0d]: got %h, required %h", it, chain, e); end
            if (ns != CL) begin errors++; $display("FAIL rand_load_shifts[%0d]: got %0d", it, ns); end
            if (da != CL + 1 + ni) begin errors++; $display("FAIL rand_load_done[%0d]: got %0d, required %0d", it, da, CL + 1 + ni); end
            p = (it == 0) ? CL - 1 : (it == 1) ? CL : $urandom_range(0, 23);
            flip = 24'd1 << p;
            f0 = w0 ^ flip[7:0]; f1 = w1 ^ flip[15:8]; f2 = w2 ^ flip[23:16];
            exp_es = (p < CL) ? p + 1 : -1;
            run_pass(1'b1, f0, f1, f2, 0, -1, 1'b1, ns, ni, da, es, ead, rl, hb, c1, fc);
            checks += 2;
            if (es != exp_es) begin errors++; $display("FAIL rand_verify_err[%0d]: flip bit %0d rose after %0d, required %0d", it, p, es, exp_es); end
            if (chain !== e) begin errors++; $display("FAIL rand_verify_chain[%0d]: got %h, required %h", it, chain, e); end
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [7:0] w [3];
        logic [CL-1:0] e;
        int c, n, wi;
        bit hit;
        for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
        c = 0; n = 0; wi = 0; hit = 1'b0;
        @(negedge prog_clk);
        cmd_start = 1'b1; cmd_verify = 1'b0;
        while (c < 60 && !hit) begin
            @(negedge prog_clk);
            c++;
            cmd_start = (c == 3);
            cmd_verify = 1'b1;
            if (chain_shift_en) n++;
            if (n == 10) begin
                hit = 1'b1;
                prog_reset = 1'b1;
                #1;
                checks++;
                if ({s_ready, ccff_head, chain_shift_en, busy, done, verify_err} !== 6'b0) begin
                    errors++;
                    $display("FAIL mid_reset_outputs: got %b, required 000000",
                             {s_ready, ccff_head, chain_shift_en, busy, done, verify_err});
                end
            end else begin
                s_valid = 1'b0;
                if (s_ready && wi < 3) begin s_valid = 1'b1; s_data = w[wi]; wi++; end
            end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_reset_reach: shift 10 not reached, shifts=%0d", n); end
        cmd_start = 1'b0; s_valid = 1'b0;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
        e = exp_chain(w[0], w[1], w[2]);
        run_pass(1'b0, w[0], w[1], w[2], 0, -1, 1'b0, ns, ni, da, es, ead, rl, hb, c1, fc);
        checks += 2;
        if (chain !== e) begin errors++; $display("FAIL post_reset_chain: got %h, required %h", chain, e); end
        if (da != CL + 2) begin errors++; $display("FAIL post_reset_done: got %0d, required %0d", da, CL + 2); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall_load();
        test_verify();
        test_random();
        test_reset_mid_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
